// File: rtl/systolic_array_out_buffer_pkg.sv
// Shared types and width helpers for the systolic-array output buffer.
package systolic_pkg;

   localparam int FP16_W = 16;

   typedef logic [FP16_W-1:0] fp16_t;

   // Beats needed to assemble one row of dim values at lanes values per beat.
   function automatic int calc_beats(input int dim, input int lanes);
      return dim / lanes;
   endfunction

   // Bits needed to hold any value 0..n inclusive.
   function automatic int cnt_width(input int n);
      return (n > 0) ? $clog2(n + 1) : 1;
   endfunction

   // Pointer width for a depth-entry memory; at least one bit.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/systolic_array_out_buffer_row_fifo.sv
// Synchronous row FIFO: registered storage, head data is always mem[rd_ptr].
// A push into a full FIFO is taken only when a pop happens in the same cycle.
module systolic_row_fifo
   import systolic_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4,
   localparam int CNT_W = cnt_width(DEPTH),
   localparam int PTR_W = ptr_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr];

   // Pointer, occupancy and storage update; pointers wrap at DEPTH-1.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (do_pop)
            rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/systolic_array_out_buffer.sv
// Output buffer for the systolic array: assembles LANES-wide beats into rows of
// ARRAY_DIM values and queues completed rows for the writeback side.
module systolic_array_out_buffer
   import systolic_pkg::*;
#(
   parameter int ARRAY_DIM = 4,
   parameter int DATA_W    = FP16_W,
   parameter int LANES     = 1,
   parameter int DEPTH     = 4,
   localparam int BEATS    = calc_beats(ARRAY_DIM, LANES),
   localparam int CNT_W    = cnt_width(DEPTH),
   localparam int BI_W     = cnt_width(BEATS),
   localparam int LW       = DATA_W * LANES,
   localparam int ROW_W    = DATA_W * ARRAY_DIM
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             shift,
   input  logic [LW-1:0]    shift_value,
   output logic             shift_ready,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ROW_W-1:0] out,
   output logic [CNT_W-1:0] count,
   output logic [BI_W-1:0]  beat_idx,
   output logic             dropped
);

   if ((ARRAY_DIM % LANES) != 0) begin : g_bad_lanes
      $error("ARRAY_DIM must be a multiple of LANES");
   end
   if (DEPTH < 1) begin : g_bad_depth
      $error("DEPTH must be at least 1");
   end

   logic [ROW_W-1:0] asm_reg;
   logic [ROW_W-1:0] row_next;
   logic             fifo_full;
   logic             fifo_empty;
   logic             pop;
   logic             last_beat;
   logic             accept;
   logic             complete;
   logic             drop_ev;

   // New values enter the top slots; older values move toward slot 0.
   assign row_next    = (asm_reg >> LW) | (ROW_W'(shift_value) << (ROW_W - LW));
   assign last_beat   = (beat_idx == BI_W'(BEATS - 1));
   assign out_valid   = ~fifo_empty;
   assign pop         = out_valid & out_ready;
   assign shift_ready = ~last_beat | ~fifo_full | pop;
   assign accept      = shift & shift_ready & ~flush;
   assign complete    = accept & last_beat;
   assign drop_ev     = shift & ~shift_ready & ~flush;

   // Assembly register and beat counter; flush outranks an incoming beat.
   always_ff @(posedge CLK) begin
      if (RST) begin
         asm_reg  <= '0;
         beat_idx <= '0;
      end else if (flush) begin
         asm_reg  <= '0;
         beat_idx <= '0;
      end else if (accept) begin
         asm_reg  <= row_next;
         beat_idx <= last_beat ? '0 : beat_idx + 1'b1;
      end
   end

   // Sticky drop flag, cleared only by reset.
   always_ff @(posedge CLK) begin
      if (RST)          dropped <= 1'b0;
      else if (drop_ev) dropped <= 1'b1;
   end

   systolic_row_fifo #(
      .WIDTH (ROW_W),
      .DEPTH (DEPTH)
   ) u_row_fifo (
      .clk   (CLK),
      .rst   (RST),
      .push  (complete),
      .pop   (pop),
      .wdata (row_next),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (count),
      .rdata (out)
   );

endmodule

// File: tb/tb_systolic_array_out_buffer.sv
// Scoreboard bench: stimulus pushes expected rows, monitors pop and compare
// on every accepted output transfer.
module tb_systolic_array_out_buffer;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;

   // Instance A: ARRAY_DIM=4, LANES=1, DEPTH=4
   logic        shift = 1'b0;
   logic [15:0] shift_value = '0;
   logic        shift_ready;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out;
   logic [2:0]  count;
   logic [2:0]  beat_idx;
   logic        dropped;

   // Instance B: ARRAY_DIM=4, LANES=2, DEPTH=4
   logic        shift2 = 1'b0;
   logic [31:0] shift_value2 = '0;
   logic        shift_ready2;
   logic        flush2 = 1'b0;
   logic        out_valid2;
   logic        out_ready2 = 1'b1;
   logic [63:0] out2;
   logic [2:0]  count2;
   logic [1:0]  beat_idx2;
   logic        dropped2;

   int total = 0;
   int bad   = 0;

   logic [63:0] exp_q  [$];
   logic [63:0] exp_q2 [$];

   always #5 CLK = ~CLK;

   systolic_array_out_buffer #(.ARRAY_DIM(4), .DATA_W(16), .LANES(1), .DEPTH(4)) dut (
      .CLK(CLK), .RST(RST), .shift(shift), .shift_value(shift_value),
      .shift_ready(shift_ready), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out(out), .count(count), .beat_idx(beat_idx),
      .dropped(dropped)
   );

   systolic_array_out_buffer #(.ARRAY_DIM(4), .DATA_W(16), .LANES(2), .DEPTH(4)) dut2 (
      .CLK(CLK), .RST(RST), .shift(shift2), .shift_value(shift_value2),
      .shift_ready(shift_ready2), .flush(flush2), .out_valid(out_valid2),
      .out_ready(out_ready2), .out(out2), .count(count2), .beat_idx(beat_idx2),
      .dropped(dropped2)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor for instance A: a transfer happens at the next rising edge.
   always @(negedge CLK) begin
      if (!RST && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL row_out_a: got %h expected none", out);
         end else begin
            check("row_out_a", out, exp_q.pop_front());
         end
      end
   end

   // Monitor for instance B.
   always @(negedge CLK) begin
      if (!RST && out_valid2 && out_ready2) begin
         if (exp_q2.size() == 0) begin
            total++;
            bad++;
            $display("FAIL row_out_b: got %h expected none", out2);
         end else begin
            check("row_out_b", out2, exp_q2.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic send_beat(input logic [15:0] v);
      shift = 1'b1;
      shift_value = v;
      step();
      shift = 1'b0;
   endtask

   // Sends the first nb values of row (slot 0 first).
   task automatic send_row(input logic [63:0] row, input int nb);
      for (int j = 0; j < nb; j++) send_beat(row[16*j +: 16]);
   endtask

   localparam logic [63:0] R1 = 64'h4444_3333_2222_1111;
   localparam logic [63:0] R2 = 64'h5004_5003_5002_5001;
   localparam logic [63:0] R3 = 64'h6004_6003_6002_6001;
   localparam logic [63:0] R4 = 64'h7004_7003_7002_7001;
   localparam logic [63:0] R5 = 64'h8004_8003_8002_8001;
   localparam logic [63:0] R6 = 64'h9004_9003_9002_9001;
   localparam logic [63:0] RC = 64'h0C04_0C03_0C02_0C01;
   localparam logic [63:0] RL = 64'h000D_000C_000B_000A;

   initial begin
      logic [63:0] row_tmp;

      // Reset state
      RST = 1'b1;
      step();
      step();
      RST = 1'b0;
      check("rst_count", count, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out", out, 0);
      check("rst_beat_idx", beat_idx, 0);
      check("rst_dropped", dropped, 0);
      check("rst_shift_ready", shift_ready, 1);

      // Two-lane assembly on instance B
      check("l2_beat_idx0", beat_idx2, 0);
      shift2 = 1'b1;
      shift_value2 = 32'h000B_000A;
      step();
      check("l2_beat_idx1", beat_idx2, 1);
      shift_value2 = 32'h000D_000C;
      exp_q2.push_back(RL);
      step();
      shift2 = 1'b0;
      check("l2_beat_idx2", beat_idx2, 0);
      check("l2_valid", out_valid2, 1);
      check("l2_out", out2, RL);
      step();
      check("l2_drained", count2, 0);

      // Flush with a concurrent beat, then a clean row
      out_ready = 1'b1;
      send_beat(16'h0A01);
      send_beat(16'h0A02);
      check("fl_beat_idx_pre", beat_idx, 2);
      flush = 1'b1;
      shift = 1'b1;
      shift_value = 16'h0BAD;
      step();
      flush = 1'b0;
      shift = 1'b0;
      check("fl_beat_idx", beat_idx, 0);
      check("fl_dropped", dropped, 0);
      check("fl_count", count, 0);
      exp_q.push_back(RC);
      send_row(RC, 4);
      check("fl_valid", out_valid, 1);
      check("fl_out", out, RC);
      step();
      check("fl_drained", count, 0);

      // Fill the FIFO with consumer stalled
      out_ready = 1'b0;
      exp_q.push_back(R1);
      send_row(R1, 4);
      check("r1_valid", out_valid, 1);
      check("r1_out", out, R1);
      check("r1_count", count, 1);
      exp_q.push_back(R2);
      send_row(R2, 4);
      exp_q.push_back(R3);
      send_row(R3, 4);
      exp_q.push_back(R4);
      send_row(R4, 4);
      check("full_count", count, 4);

      // Full FIFO: completing beat with a concurrent pop
      send_row(R5, 3);
      check("r5_beat_idx", beat_idx, 3);
      out_ready = 1'b1;
      shift = 1'b1;
      shift_value = R5[63:48];
      #1;
      check("pp_shift_ready", shift_ready, 1);
      exp_q.push_back(R5);
      step();
      shift = 1'b0;
      out_ready = 1'b0;
      check("pp_count", count, 4);
      check("pp_dropped", dropped, 0);
      check("pp_head", out, R2);

      // Full FIFO without pop: completing beat is dropped
      send_row(R6, 3);
      shift = 1'b1;
      shift_value = R6[63:48];
      #1;
      check("dr_shift_ready", shift_ready, 0);
      step();
      shift = 1'b0;
      check("dr_dropped", dropped, 1);
      check("dr_count", count, 4);
      check("dr_beat_idx", beat_idx, 3);
      check("dr_head", out, R2);

      // Drain, then keep ready asserted on an empty FIFO
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) step();
      out_ready = 1'b0;
      check("dn_count", count, 0);
      check("dn_valid", out_valid, 0);
      check("dn_dropped_sticky", dropped, 1);

      // Reset mid-row with rows queued
      flush = 1'b1;
      step();
      flush = 1'b0;
      for (int r = 0; r < 3; r++) begin
         row_tmp = {16'hE004, 16'hE003, 16'hE002, 16'(16'hE001 + r)};
         send_row(row_tmp, 4);
      end
      send_row(64'h0000_0000_F002_F001, 2);
      check("mr_count", count, 3);
      check("mr_beat_idx", beat_idx, 2);
      RST = 1'b1;
      step();
      RST = 1'b0;
      check("mr_rst_count", count, 0);
      check("mr_rst_valid", out_valid, 0);
      check("mr_rst_out", out, 0);
      check("mr_rst_beat_idx", beat_idx, 0);
      check("mr_rst_dropped", dropped, 0);

      check("sb_left_a", 64'(exp_q.size()), 0);
      check("sb_left_b", 64'(exp_q2.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Safety net against a stalled run.
   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
